// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_pkg
// Description : Shared definitions for the sequential ALU. These are the
//               opcode mnemonics (the legacy op_mne set extended with
//               OR/ADD/SUB/LSHN/RSHN/ROLN/RORN), the FSM state enum and the
//               default datapath width.
//               Optional feature macro: SEQ_ALU_ROTATE_EN (ROLN/RORN).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    // Default datapath width for seq_alu and its parity tree.
    localparam int unsigned SEQ_ALU_WIDTH = 8;

    // Opcodes. Codes 11..15 are unassigned and act as no-ops. ROLN/RORN are
    // also no-ops unless rotates are compiled in.
    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_LSH  = 4'd5,
        OP_RSH  = 4'd6,
        OP_LSHN = 4'd7,
        OP_RSHN = 4'd8,
        OP_ROLN = 4'd9,
        OP_RORN = 4'd10
    } op_mne;

    // Sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage : seq_alu_pkg
`default_nettype wire

// File: rtl/seq_alu_parity.sv
`default_nettype none
// ============================================================================
// Module      : parity_tree
// Description : Combinational XOR reduction of a WIDTH-bit word.
//               o_parity = 1 when the word holds an odd number of ones.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_tree
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = SEQ_ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_parity
);

    // Reduction XOR; synthesis balances it into a log-depth tree.
    assign o_parity = ^i_data;

endmodule : parity_tree
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Clocked ALU with a START/BUSY/DONE handshake. Logic and
//               arithmetic ops complete in one cycle. Multi-bit shifts and
//               rotates run one bit per cycle in the SHIFT state. Results and
//               flags (sc_out, zero, beven) stay registered until the next
//               completion.
//               Optional feature macro: SEQ_ALU_ROTATE_EN adds ROLN/RORN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter  int WIDTH   = SEQ_ALU_WIDTH,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] inputa,
    input  logic [WIDTH-1:0] inputb,
    input  logic             sc_in,
    output logic [WIDTH-1:0] out,
    output logic             sc_out,
    output logic             zero,
    output logic             beven,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0]         c_st_idle  = ST_IDLE;
    localparam logic [0:0]         c_st_shift = ST_SHIFT;
    localparam logic [SHAMT_W-1:0] c_cnt_one  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    // Sequencer and shift datapath state
    logic [0:0]         r_state;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_work;
    logic [3:0]         r_op;
    logic               r_fill;

    // Result registers
    logic [WIDTH-1:0]   r_out;
    logic               r_sc;
    logic               r_zero;
    logic               r_beven;
    logic               r_done;

    // Combinational results
    logic [SHAMT_W-1:0] w_n;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [WIDTH-1:0]   w_res;
    logic               w_res_sc;
    logic               w_go_shift;
    logic [WIDTH-1:0]   w_step_work;
    logic               w_step_bit;
    logic               w_wr_en;
    logic [WIDTH-1:0]   w_wr_val;
    logic               w_wr_sc;
    logic               w_parity;

    assign w_n   = inputb[SHAMT_W-1:0];
    assign w_sum = {1'b0, inputa} + {1'b0, inputb}  + {{WIDTH{1'b0}}, sc_in};
    assign w_dif = {1'b0, inputa} + {1'b0, ~inputb} + {{WIDTH{1'b0}}, sc_in};

    // Decode a new request. Either produce the single-cycle result or flag
    // that a multi-cycle shift must be started.
    always_comb begin
        w_res      = '0;
        w_res_sc   = 1'b0;
        w_go_shift = 1'b0;
        case (op)
            OP_AND: w_res = inputa & inputb;
            OP_OR:  w_res = inputa | inputb;
            OP_XOR: w_res = inputa ^ inputb;
            OP_ADD: {w_res_sc, w_res} = w_sum;
            OP_SUB: {w_res_sc, w_res} = w_dif;
            OP_LSH: {w_res_sc, w_res} = {inputa, sc_in};
            OP_RSH: {w_res, w_res_sc} = {sc_in, inputa};
`ifdef SEQ_ALU_ROTATE_EN
            OP_LSHN, OP_RSHN, OP_ROLN, OP_RORN: begin
`else
            OP_LSHN, OP_RSHN: begin
`endif
                // A zero shift amount finishes at once with A passed through.
                if (w_n == '0) begin
                    w_res = inputa;
                end else begin
                    w_go_shift = 1'b1;
                end
            end
            default: begin
                w_res    = '0;
                w_res_sc = 1'b0;
            end
        endcase
    end

    // One-bit step of the working register for the latched shift/rotate op.
    always_comb begin
        w_step_work = r_work;
        w_step_bit  = 1'b0;
        case (r_op)
            OP_LSHN: {w_step_bit, w_step_work} = {r_work, r_fill};
            OP_RSHN: {w_step_work, w_step_bit} = {r_fill, r_work};
`ifdef SEQ_ALU_ROTATE_EN
            OP_ROLN: begin
                w_step_work = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
                w_step_bit  = r_work[WIDTH-1];
            end
            OP_RORN: begin
                w_step_work = {r_work[0], r_work[WIDTH-1:1]};
                w_step_bit  = r_work[0];
            end
`endif
            default: begin
                w_step_work = r_work;
                w_step_bit  = 1'b0;
            end
        endcase
    end

    // Select what is committed to the result registers this cycle, if anything.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_val = r_out;
        w_wr_sc  = r_sc;
        if (r_state == c_st_idle) begin
            if (start && !w_go_shift) begin
                w_wr_en  = 1'b1;
                w_wr_val = w_res;
                w_wr_sc  = w_res_sc;
            end
        end else if (r_cnt == c_cnt_one) begin
            w_wr_en  = 1'b1;
            w_wr_val = w_step_work;
            w_wr_sc  = w_step_bit;
        end
    end

    parity_tree #(
        .WIDTH (WIDTH)
    ) u_parity (
        .i_data   (w_wr_val),
        .o_parity (w_parity)
    );

    // Result and flag registers. They change only on a completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_sc    <= 1'b0;
            r_zero  <= 1'b1;
            r_beven <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_wr_en;
            if (w_wr_en) begin
                r_out   <= w_wr_val;
                r_sc    <= w_wr_sc;
                r_zero  <= (w_wr_val == '0);
                r_beven <= w_parity;
            end
        end
    end

    // Sequencer. Accept a shift in IDLE, then step once per cycle until the
    // counter expires. Requests arriving while shifting are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_work  <= '0;
            r_op    <= 4'd0;
            r_fill  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start && w_go_shift) begin
                        r_state <= c_st_shift;
                        r_cnt   <= w_n;
                        r_work  <= inputa;
                        r_op    <= op;
                        r_fill  <= sc_in;
                    end
                end
                default: begin
                    r_work <= w_step_work;
                    r_cnt  <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= c_st_idle;
                    end
                end
            endcase
        end
    end

    assign out    = r_out;
    assign sc_out = r_sc;
    assign zero   = r_zero;
    assign beven  = r_beven;
    assign done   = r_done;
    assign busy   = (r_state == c_st_shift);

endmodule : seq_alu
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu (WIDTH=8). A behavioural model
//               predicts each result and its latency up front. Outputs are
//               compared against the model on every falling edge, and
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sc_in;
    logic [W-1:0] out;
    logic         sc_out;
    logic         zero;
    logic         beven;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .inputa (a),
        .inputb (b),
        .sc_in  (sc_in),
        .out    (out),
        .sc_out (sc_out),
        .zero   (zero),
        .beven  (beven),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result and latency of one request, from the operation definitions.
    function automatic void predict(input logic [3:0] f_op, input logic [W-1:0] fa,
                                    input logic [W-1:0] fb, input logic fc,
                                    output logic [W-1:0] r, output logic rs,
                                    output int lat);
        logic [W:0]   s;
        logic [W-1:0] nb;
        int           n;
        n   = int'(fb % W);
        r   = '0;
        rs  = 1'b0;
        lat = 0;
        nb  = ~fb;
        case (f_op)
            4'd0: r = fa & fb;
            4'd1: r = fa | fb;
            4'd2: r = fa ^ fb;
            4'd3: begin s = {1'b0, fa} + {1'b0, fb} + fc; r = s[W-1:0]; rs = s[W]; end
            4'd4: begin s = {1'b0, fa} + {1'b0, nb} + fc; r = s[W-1:0]; rs = s[W]; end
            4'd5: begin rs = fa[W-1]; r = {fa[W-2:0], fc}; end
            4'd6: begin rs = fa[0];   r = {fc, fa[W-1:1]}; end
            4'd7, 4'd8: begin
                r   = fa;
                lat = n;
                for (int i = 0; i < n; i++) begin
                    if (f_op == 4'd7) begin rs = r[W-1]; r = {r[W-2:0], fc}; end
                    else              begin rs = r[0];   r = {fc, r[W-1:1]}; end
                end
            end
`ifdef SEQ_ALU_ROTATE_EN
            4'd9, 4'd10: begin
                r   = fa;
                lat = n;
                for (int i = 0; i < n; i++) begin
                    if (f_op == 4'd9) begin rs = r[W-1]; r = {r[W-2:0], r[W-1]}; end
                    else              begin rs = r[0];   r = {r[0], r[W-1:1]}; end
                end
            end
`endif
            default: begin r = '0; rs = 1'b0; end
        endcase
    endfunction

    // Model state: visible outputs plus one pending multi-cycle result.
    logic [W-1:0] m_out, p_out, t_r;
    logic         m_sc, m_zero, m_beven, m_busy, m_done, p_sc, t_rs;
    int           m_remain, t_lat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out = '0; m_sc = 1'b0; m_zero = 1'b1; m_beven = 1'b0;
            m_busy = 1'b0; m_done = 1'b0; m_remain = 0;
        end else begin
            m_done = 1'b0;
            if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_out = p_out; m_sc = p_sc; m_zero = (p_out == '0);
                    m_beven = ($countones(p_out) % 2) == 1; m_done = 1'b1; m_busy = 1'b0;
                end
            end else if (start) begin
                predict(op, a, b, sc_in, t_r, t_rs, t_lat);
                if (t_lat == 0) begin
                    m_out = t_r; m_sc = t_rs; m_zero = (t_r == '0);
                    m_beven = ($countones(t_r) % 2) == 1; m_done = 1'b1;
                end else begin
                    p_out = t_r; p_sc = t_rs; m_remain = t_lat; m_busy = 1'b1;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        chk("cyc_out",    32'(out),    32'(m_out));
        chk("cyc_sc_out", 32'(sc_out), 32'(m_sc));
        chk("cyc_zero",   32'(zero),   32'(m_zero));
        chk("cyc_beven",  32'(beven),  32'(m_beven));
        chk("cyc_busy",   32'(busy),   32'(m_busy));
        chk("cyc_done",   32'(done),   32'(m_done));
    end

    // Present a request for one cycle. It is called at a falling edge and
    // returns at the next one.
    task automatic go(input logic [3:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic);
        start = 1'b1; op = o; a = ia; b = ib; sc_in = ic;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        rst_n = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0; sc_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out",   32'(out),  32'h0);
        chk("reset_zero",  32'(zero), 32'h1);
        chk("reset_beven", 32'(beven), 32'h0);
        chk("reset_busy",  32'(busy), 32'h0);
        chk("reset_done",  32'(done), 32'h0);

        // ADD wraps to zero with carry out
        go(4'd3, 8'hFF, 8'h01, 1'b0);
        chk("add_done",  32'(done),   32'h1);
        chk("add_out",   32'(out),    32'h00);
        chk("add_sc",    32'(sc_out), 32'h1);
        chk("add_zero",  32'(zero),   32'h1);
        chk("add_beven", 32'(beven),  32'h0);
        chk("add_busy",  32'(busy),   32'h0);
        @(negedge clk);
        chk("add_done_pulse", 32'(done), 32'h0);

        // SUB with borrow, then XOR issued in the DONE cycle
        go(4'd4, 8'h05, 8'h07, 1'b1);
        chk("sub_out",   32'(out),    32'hFE);
        chk("sub_sc",    32'(sc_out), 32'h0);
        chk("sub_zero",  32'(zero),   32'h0);
        chk("sub_beven", 32'(beven),  32'h1);
        go(4'd2, 8'h3C, 8'h3C, 1'b0);
        chk("xor_b2b_out",  32'(out),  32'h00);
        chk("xor_b2b_zero", 32'(zero), 32'h1);
        chk("xor_b2b_done", 32'(done), 32'h1);

        // Nonzero result so that "unchanged during SHIFT" is observable
        go(4'd1, 8'h11, 8'h22, 1'b0);
        chk("or_out", 32'(out), 32'h33);

        // LSHN by 3 with an AND request dropped while busy
        go(4'd7, 8'h81, 8'h03, 1'b0);
        chk("lshn_busy1", 32'(busy), 32'h1);
        chk("lshn_hold1", 32'(out),  32'h33);
        start = 1'b1; op = 4'd0; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        chk("lshn_busy2", 32'(busy), 32'h1);
        chk("lshn_hold2", 32'(out),  32'h33);
        @(negedge clk);
        chk("lshn_busy3", 32'(busy), 32'h1);
        chk("lshn_hold3", 32'(out),  32'h33);
        @(negedge clk);
        chk("lshn_done",  32'(done),   32'h1);
        chk("lshn_busy0", 32'(busy),   32'h0);
        chk("lshn_out",   32'(out),    32'h08);
        chk("lshn_sc",    32'(sc_out), 32'h0);
        chk("lshn_beven", 32'(beven),  32'h1);
        @(negedge clk);
        chk("busy_and_dropped_done", 32'(done), 32'h0);
        chk("busy_and_dropped_out",  32'(out),  32'h08);

        // RSHN by 1 shifting in a one
        go(4'd8, 8'h81, 8'h01, 1'b1);
        chk("rshn_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("rshn_done", 32'(done),   32'h1);
        chk("rshn_out",  32'(out),    32'hC0);
        chk("rshn_sc",   32'(sc_out), 32'h1);

        // LSHN by 0 finishes in one cycle
        go(4'd7, 8'h5A, 8'h00, 1'b1);
        chk("lshn0_done", 32'(done),   32'h1);
        chk("lshn0_busy", 32'(busy),   32'h0);
        chk("lshn0_out",  32'(out),    32'h5A);
        chk("lshn0_sc",   32'(sc_out), 32'h0);

        // Unassigned opcode
        go(4'd15, 8'hAA, 8'h55, 1'b1);
        chk("op15_done", 32'(done),   32'h1);
        chk("op15_out",  32'(out),    32'h00);
        chk("op15_zero", 32'(zero),   32'h1);
        chk("op15_sc",   32'(sc_out), 32'h0);

        go(4'd3, 8'h12, 8'h34, 1'b0);
        chk("add2_out", 32'(out), 32'h46);

        // Asynchronous reset in the 2nd cycle of LSHN n=5
        go(4'd7, 8'h33, 8'h05, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out",   32'(out),    32'h0);
        chk("arst_sc",    32'(sc_out), 32'h0);
        chk("arst_zero",  32'(zero),   32'h1);
        chk("arst_beven", 32'(beven),  32'h0);
        chk("arst_busy",  32'(busy),   32'h0);
        chk("arst_done",  32'(done),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("arst_no_done", 32'(dn), 32'h0);

        // ROLN by 1
        go(4'd9, 8'h81, 8'h01, 1'b0);
`ifdef SEQ_ALU_ROTATE_EN
        chk("roln_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("roln_done", 32'(done),   32'h1);
        chk("roln_out",  32'(out),    32'h03);
        chk("roln_sc",   32'(sc_out), 32'h1);
`else
        chk("roln_done", 32'(done),   32'h1);
        chk("roln_out",  32'(out),    32'h00);
        chk("roln_sc",   32'(sc_out), 32'h0);
`endif
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_alu
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Parametrised, clocked successor to the basic processor's combinational ALU. Operands and opcode are accepted on a START handshake, and results plus flags are held in registers. Multi-bit shifts (and optional rotates) run one bit per cycle under a small state machine. The block sits in the execute stage; the controller stalls on BUSY and captures results on DONE.

## Interface
Parameters:
- WIDTH, 8, datapath width; power of 2, ≥ 4
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET_N  input  1  reset; asynchronous, active-low
- START  input  1  request; sampled only while BUSY=0
- OP  input  4  opcode, from the shared package enum
- INPUTA  input  WIDTH  operand A
- INPUTB  input  WIDTH  operand B; INPUTB[SHAMT_W-1:0] is the shift amount
- SC_IN  input  1  carry-in / shift-in
- OUT  output  WIDTH  registered result
- SC_OUT  output  1  registered carry-out / last bit shifted out
- ZERO  output  1  registered, OUT==0
- BEVEN  output  1  registered parity of OUT: 0 for an even number of ones, 1 for odd
- BUSY  output  1  multi-cycle operation in progress
- DONE  output  1  one-cycle pulse; result valid

## Operation
- States: IDLE and SHIFT.
- In IDLE, START=1 latches OP, INPUTA, INPUTB and SC_IN.
- Single-cycle ops:
  - 0 AND, 1 OR, 2 XOR: SC_OUT=0.
  - 3 ADD: {SC_OUT,OUT}=A+B+SC_IN, computed at WIDTH+1 bits.
  - 4 SUB: {SC_OUT,OUT}=A+~B+SC_IN. Plain subtract uses SC_IN=1; SC_OUT=1 means no borrow.
  - 5 LSH: {SC_OUT,OUT}={A,SC_IN}.
  - 6 RSH: {OUT,SC_OUT}={SC_IN,A}.
- Multi-cycle ops:
  - 7 LSHN, 8 RSHN: shift by n=INPUTB[SHAMT_W-1:0], filling each vacated bit with SC_IN. SC_OUT is the last bit shifted out.
  - n=0 completes like a single-cycle op with OUT=A, SC_OUT=0.
  - n>0: go to SHIFT with a working register = A and a counter = n. One bit shifts per cycle and the counter decrements. When the counter reaches 0, the working register is written to OUT and the FSM returns to IDLE.
- Any other code (including 9/10 when rotates are compiled out): OUT=0, SC_OUT=0, DONE still pulses.
- ZERO and BEVEN are computed from the value being written to OUT and registered with it.
- OUT, SC_OUT, ZERO and BEVEN hold their values until the next completion. They do not change during SHIFT.
- START while BUSY=1 is ignored. No queueing.

## Timing
- Reset values: OUT=0, SC_OUT=0, ZERO=1, BEVEN=0, BUSY=0, DONE=0; FSM=IDLE, counter=0.
- Assertion of RESET_N takes effect immediately, mid-operation included. The operation is aborted and no DONE follows.
- Single-cycle ops: START sampled at edge k; results and DONE=1 are visible in the cycle after edge k. DONE lasts exactly one cycle.
- Shift with n>0:
  - BUSY=1 from edge k through the edge that completes the shift.
  - Result and DONE appear n cycles after the START edge, with BUSY=0 in the DONE cycle.
- Back-to-back: START is accepted in the DONE cycle, giving one result per cycle for single-cycle ops.
- Maximum latency is WIDTH-1 cycles.

## Configuration
- SEQ_ALU_ROTATE_EN defined:
  - Adds op 9 ROLN and op 10 RORN, using the same SHIFT state, counter and latency as LSHN/RSHN.
  - SC_IN is ignored; SC_OUT is the last bit rotated out.
  - n=0 gives OUT=A, SC_OUT=0.
- Undefined: codes 9 and 10 behave as no-op, and no rotate logic is synthesised.

## Structure
- Shared package (definitions): 4-bit op enum extending op_mne with OR/ADD/SUB/LSHN/RSHN/ROLN/RORN, the FSM state enum, and the default WIDTH constant.
- One sub-module, parity_tree #(WIDTH): combinational XOR reduction producing BEVEN from the next-OUT value.
- The FSM, counter, working register and result registers stay in seq_alu.

## Test plan
1. ADD, WIDTH=8: A=0xFF, B=0x01, SC_IN=0 -> OUT=0x00, SC_OUT=1, ZERO=1, BEVEN=0. DONE one cycle after START; BUSY never high.
2. SUB: A=0x05, B=0x07, SC_IN=1 -> OUT=0xFE, SC_OUT=0, ZERO=0, BEVEN=1. Then immediately, in the DONE cycle, XOR A=B=0x3C -> OUT=0x00, ZERO=1 on the next cycle.
3. LSHN: A=0x81, B=3, SC_IN=0 -> BUSY high for 3 cycles, OUT unchanged until DONE. Then OUT=0x08, SC_OUT=0, BEVEN=1. Also RSHN A=0x81, B=1, SC_IN=1 -> OUT=0xC0, SC_OUT=1.
4. Handshake and boundary:
   - START with AND while BUSY -> ignored; the shift result is unaffected.
   - LSHN with B=0 -> DONE after 1 cycle, OUT=A, SC_OUT=0.
   - OP=15 -> OUT=0, ZERO=1, DONE pulses.
5. Reset: RESET_N low in the 2nd cycle of LSHN n=5 -> outputs at reset values immediately. After release, no DONE until a new START.
6. ROLN A=0x81, B=1:
   - With SEQ_ALU_ROTATE_EN: OUT=0x03, SC_OUT=1.
   - Without: OUT=0x00, SC_OUT=0, DONE after 1 cycle.
